// File: rtl/sparc_cc_pkg.sv
// rtl/sparc_cc_pkg.sv - shared flag, condition-code and opcode definitions for the SPARC icc unit
package sparc_cc_pkg;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    localparam int PSR_ET = 5;

    localparam logic [1:0] OP_FMT2  = 2'b00;
    localparam logic [1:0] OP_ARITH = 2'b10;

    typedef enum logic [3:0] {
        NEVER  = 4'h0,
        E      = 4'h1,
        LE     = 4'h2,
        L      = 4'h3,
        LEU    = 4'h4,
        CS     = 4'h5,
        NEG    = 4'h6,
        VS     = 4'h7,
        ALWAYS = 4'h8,
        NE     = 4'h9,
        G      = 4'hA,
        GE     = 4'hB,
        GU     = 4'hC,
        CC     = 4'hD,
        POS    = 4'hE,
        VC     = 4'hF
    } cond_e;

endpackage

// File: rtl/cc_eval.sv
// rtl/cc_eval.sv - combinational Bicc/Ticc condition evaluation against {C,N,V,Z}
module cc_eval
    import sparc_cc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_true
);

    logic c, n, v, z;

    assign c = flags[FLAG_C];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];
    assign z = flags[FLAG_Z];

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            NEVER:   cond_true = 1'b0;
            E:       cond_true = z;
            LE:      cond_true = z | (n ^ v);
            L:       cond_true = n ^ v;
            LEU:     cond_true = c | z;
            CS:      cond_true = c;
            NEG:     cond_true = n;
            VS:      cond_true = v;
            ALWAYS:  cond_true = 1'b1;
            NE:      cond_true = ~z;
            G:       cond_true = ~(z | (n ^ v));
            GE:      cond_true = ~(n ^ v);
            GU:      cond_true = ~(c | z);
            CC:      cond_true = ~c;
            POS:     cond_true = ~n;
            VC:      cond_true = ~v;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/condition_tester.sv
// rtl/condition_tester.sv - icc flag register, branch/trap condition and window checks; option FLAG_BYPASS_EN
module condition_tester
    import sparc_cc_pkg::*;
#(
    parameter int NWINDOWS = 4
)
(
    input  logic                Clk,
    input  logic                Clr,
    input  logic                FR_Ld,
    input  logic                MF,
    input  logic [3:0]          alu_flags,
    input  logic [3:0]          wr_icc,
    input  logic [6:0]          ir_hi,
    input  logic [NWINDOWS-1:0] wim,
    input  logic [11:0]         psr,
    output logic [3:0]          fr_out,
    output logic                BCOND,
    output logic                TCOND,
    output logic                win_ovf,
    output logic                win_unf
);

    localparam int CW = (NWINDOWS > 1) ? $clog2(NWINDOWS) : 1;
    localparam logic [CW-1:0] CWP_LAST = CW'(NWINDOWS - 1);

    logic [3:0]    fr_q;
    logic [3:0]    flag_src;
    logic [3:0]    eval_flags;
    logic [1:0]    op;
    logic          cond_true;
    logic [CW-1:0] cwp;
    logic [CW-1:0] ovf_idx;
    logic [CW-1:0] unf_idx;
    logic          unused_bits;

    assign flag_src = MF ? wr_icc : alu_flags;

    always_ff @(posedge Clk) begin
        if (Clr) begin
            fr_q <= 4'b0000;
        end else if (FR_Ld) begin
            fr_q <= flag_src;
        end
    end

    assign fr_out = fr_q;

`ifdef FLAG_BYPASS_EN
    // Forward the flags being loaded so a branch resolves in the same cycle.
    assign eval_flags = FR_Ld ? flag_src : fr_q;
`else
    assign eval_flags = fr_q;
`endif

    cc_eval u_cc_eval (
        .cond      (ir_hi[3:0]),
        .flags     (eval_flags),
        .cond_true (cond_true)
    );

    assign op    = ir_hi[6:5];
    assign BCOND = cond_true & (op == OP_FMT2);
    assign TCOND = cond_true & (op == OP_ARITH) & psr[PSR_ET];

    // Explicit wrap so non-power-of-two window counts stay modulo NWINDOWS.
    assign cwp     = psr[CW-1:0];
    assign ovf_idx = (cwp == '0) ? CWP_LAST : cwp - CW'(1);
    assign unf_idx = (cwp >= CWP_LAST) ? '0 : cwp + CW'(1);

    assign win_ovf = (ovf_idx <= CWP_LAST) & wim[ovf_idx];
    assign win_unf = (unf_idx <= CWP_LAST) & wim[unf_idx];

    assign unused_bits = ^{ir_hi[4], psr};

endmodule

// File: tb/tb_condition_tester.sv
// tb/tb_condition_tester.sv - self-checking bench for condition_tester
module tb_condition_tester;

    localparam int NW = 4;

    logic          Clk = 1'b0;
    logic          Clr;
    logic          FR_Ld;
    logic          MF;
    logic [3:0]    alu_flags;
    logic [3:0]    wr_icc;
    logic [6:0]    ir_hi;
    logic [NW-1:0] wim;
    logic [11:0]   psr;
    logic [3:0]    fr_out;
    logic          BCOND;
    logic          TCOND;
    logic          win_ovf;
    logic          win_unf;

    int checks = 0;
    int errors = 0;

    condition_tester #(.NWINDOWS(NW)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .FR_Ld     (FR_Ld),
        .MF        (MF),
        .alu_flags (alu_flags),
        .wr_icc    (wr_icc),
        .ir_hi     (ir_hi),
        .wim       (wim),
        .psr       (psr),
        .fr_out    (fr_out),
        .BCOND     (BCOND),
        .TCOND     (TCOND),
        .win_ovf   (win_ovf),
        .win_unf   (win_unf)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic [1:0] op;
        logic       et;
        logic       exp_b;
        logic       exp_t;
    } cc_vec_t;

    typedef struct {
        logic [3:0] wim;
        logic [1:0] cwp;
        logic       exp_ovf;
        logic       exp_unf;
    } win_vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Lower three cond bits select a base test; cond[3] negates it.
    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic fc, fn, fv, fz, base;
        fc = f[3]; fn = f[2]; fv = f[1]; fz = f[0];
        case (c[2:0])
            3'd0: base = 1'b0;
            3'd1: base = fz;
            3'd2: base = fz | (fn ^ fv);
            3'd3: base = fn ^ fv;
            3'd4: base = fc | fz;
            3'd5: base = fc;
            3'd6: base = fn;
            default: base = fv;
        endcase
        return c[3] ? ~base : base;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        FR_Ld = 1'b1; MF = 1'b1; wr_icc = f;
        tick();
        FR_Ld = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cc_vec_t  cc_tab[16];
        win_vec_t win_tab[6];
        logic [3:0] model_fr;
        logic [3:0] src;
        logic [3:0] eff;
        logic       ct;

        cc_tab[0]  = '{4'b0001, 4'b0001, 2'b00, 1'b0, 1'b1, 1'b0};
        cc_tab[1]  = '{4'b0001, 4'b1001, 2'b00, 1'b0, 1'b0, 1'b0};
        cc_tab[2]  = '{4'b0100, 4'b0011, 2'b00, 1'b0, 1'b1, 1'b0};
        cc_tab[3]  = '{4'b0100, 4'b1011, 2'b00, 1'b0, 1'b0, 1'b0};
        cc_tab[4]  = '{4'b0100, 4'b0010, 2'b00, 1'b0, 1'b1, 1'b0};
        cc_tab[5]  = '{4'b1000, 4'b0100, 2'b10, 1'b1, 1'b0, 1'b1};
        cc_tab[6]  = '{4'b1000, 4'b0100, 2'b10, 1'b0, 1'b0, 1'b0};
        cc_tab[7]  = '{4'b0000, 4'b1000, 2'b01, 1'b1, 1'b0, 1'b0};
        cc_tab[8]  = '{4'b0000, 4'b1000, 2'b11, 1'b1, 1'b0, 1'b0};
        cc_tab[9]  = '{4'b0010, 4'b0111, 2'b10, 1'b1, 1'b0, 1'b1};
        cc_tab[10] = '{4'b0010, 4'b1111, 2'b10, 1'b1, 1'b0, 1'b0};
        cc_tab[11] = '{4'b0000, 4'b1100, 2'b00, 1'b0, 1'b1, 1'b0};
        cc_tab[12] = '{4'b0110, 4'b1010, 2'b00, 1'b0, 1'b1, 1'b0};
        cc_tab[13] = '{4'b1001, 4'b1101, 2'b00, 1'b0, 1'b0, 1'b0};
        cc_tab[14] = '{4'b0000, 4'b0000, 2'b10, 1'b1, 1'b0, 1'b0};
        cc_tab[15] = '{4'b1111, 4'b1110, 2'b00, 1'b0, 1'b0, 1'b0};

        win_tab[0] = '{4'b0001, 2'd1, 1'b1, 1'b0};
        win_tab[1] = '{4'b0001, 2'd3, 1'b0, 1'b1};
        win_tab[2] = '{4'b0001, 2'd0, 1'b0, 1'b0};
        win_tab[3] = '{4'b1000, 2'd0, 1'b1, 1'b0};
        win_tab[4] = '{4'b0100, 2'd1, 1'b0, 1'b1};
        win_tab[5] = '{4'b0010, 2'd2, 1'b1, 1'b0};

        Clr = 1'b1; FR_Ld = 1'b1; MF = 1'b0; alu_flags = 4'hF; wr_icc = 4'h0;
        ir_hi = 7'b0001000; wim = '0; psr = 12'h000;
        tick();
        check("reset_fr", fr_out, 4'h0);

        Clr = 1'b0; FR_Ld = 1'b0;
        ir_hi = 7'b0001000; #1;
        check("reset_always_b", {3'b0, BCOND}, 4'h1);
        ir_hi = 7'b0000001; #1;
        check("reset_e_b", {3'b0, BCOND}, 4'h0);

        FR_Ld = 1'b1; MF = 1'b0; alu_flags = 4'b0001;
        tick();
        FR_Ld = 1'b0;
        check("load_alu_fr", fr_out, 4'b0001);
        ir_hi = 7'b0000001; #1;
        check("z_e_b", {3'b0, BCOND}, 4'h1);
        ir_hi = 7'b0001001; #1;
        check("z_ne_b", {3'b0, BCOND}, 4'h0);
        alu_flags = 4'b1110;
        tick();
        check("hold_fr", fr_out, 4'b0001);

        load_flags(4'b0100);
        check("load_wr_fr", fr_out, 4'b0100);

        for (int i = 0; i < 16; i++) begin
            load_flags(cc_tab[i].flags);
            ir_hi = {cc_tab[i].op, 1'b0, cc_tab[i].cond};
            psr   = {6'b0, cc_tab[i].et, 5'b0};
            #1;
            check($sformatf("tab%0d_b", i), {3'b0, BCOND}, {3'b0, cc_tab[i].exp_b});
            check($sformatf("tab%0d_t", i), {3'b0, TCOND}, {3'b0, cc_tab[i].exp_t});
        end

        for (int i = 0; i < 6; i++) begin
            wim = win_tab[i].wim;
            psr = {10'b0, win_tab[i].cwp};
            #1;
            check($sformatf("win%0d_ovf", i), {3'b0, win_ovf}, {3'b0, win_tab[i].exp_ovf});
            check($sformatf("win%0d_unf", i), {3'b0, win_unf}, {3'b0, win_tab[i].exp_unf});
        end

        for (int f = 0; f < 16; f++) begin
            load_flags(f[3:0]);
            for (int c = 0; c < 16; c++) begin
                ct = cond_model(c[3:0], f[3:0]);
                ir_hi = {2'b00, 1'b1, c[3:0]}; psr = 12'h020; #1;
                check($sformatf("sw_b f%0h c%0h", f, c), {3'b0, BCOND}, {3'b0, ct});
                check($sformatf("sw_bt f%0h c%0h", f, c), {3'b0, TCOND}, 4'h0);
                ir_hi = {2'b10, 1'b0, c[3:0]}; #1;
                check($sformatf("sw_t f%0h c%0h", f, c), {3'b0, TCOND}, {3'b0, ct});
                check($sformatf("sw_tb f%0h c%0h", f, c), {3'b0, BCOND}, 4'h0);
                psr = 12'h000; #1;
                check($sformatf("sw_et0 f%0h c%0h", f, c), {3'b0, TCOND}, 4'h0);
                ir_hi = {2'b01, 1'b0, c[3:0]}; psr = 12'h020; #1;
                check($sformatf("sw_op1 f%0h c%0h", f, c), {2'b0, BCOND, TCOND}, 4'h0);
            end
        end

        Clr = 1'b1;
        tick();
        Clr = 1'b0;
        FR_Ld = 1'b1; MF = 1'b0; alu_flags = 4'b0001; ir_hi = 7'b0000001; #1;
`ifdef FLAG_BYPASS_EN
        check("bypass_same_cycle", {3'b0, BCOND}, 4'h1);
`else
        check("no_bypass_same_cycle", {3'b0, BCOND}, 4'h0);
`endif
        tick();
        FR_Ld = 1'b0; #1;
        check("bypass_next_cycle", {3'b0, BCOND}, 4'h1);

        model_fr = fr_out === 4'b0001 ? 4'b0001 : 4'b0001;
        for (int n = 0; n < 400; n++) begin
            Clr       = ($urandom_range(0, 15) == 0);
            FR_Ld     = $urandom_range(0, 1);
            MF        = $urandom_range(0, 1);
            alu_flags = 4'($urandom);
            wr_icc    = 4'($urandom);
            ir_hi     = 7'($urandom);
            wim       = NW'($urandom);
            psr       = 12'($urandom);
            #1;
            src = MF ? wr_icc : alu_flags;
`ifdef FLAG_BYPASS_EN
            eff = FR_Ld ? src : model_fr;
`else
            eff = model_fr;
`endif
            ct = cond_model(ir_hi[3:0], eff);
            check($sformatf("rnd%0d_b", n), {3'b0, BCOND}, {3'b0, ct && ir_hi[6:5] == 2'b00});
            check($sformatf("rnd%0d_t", n), {3'b0, TCOND}, {3'b0, ct && ir_hi[6:5] == 2'b10 && psr[5]});
            check($sformatf("rnd%0d_ovf", n), {3'b0, win_ovf}, {3'b0, wim[(int'(psr[1:0]) + NW - 1) % NW]});
            check($sformatf("rnd%0d_unf", n), {3'b0, win_unf}, {3'b0, wim[(int'(psr[1:0]) + 1) % NW]});
            if (Clr) model_fr = 4'h0;
            else if (FR_Ld) model_fr = src;
            tick();
            check($sformatf("rnd%0d_fr", n), fr_out, model_fr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/condition_tester.md
Name: condition_tester

Overview:
- Integer condition-code unit for the SPARC datapath. It holds the 4-bit icc flag register, whose input is a 2:1 source mux between live ALU flags and a WRPSR write value.
- It evaluates the Bicc/Ticc 4-bit cond field against the stored flags, producing BCOND (branch taken) and TCOND (trap taken) for the control unit.
- It also flags register-window overflow/underflow from WIM and CWP.

Parameters:
- NWINDOWS, 4, number of register windows; CWP width is clog2(NWINDOWS) (2 bits at default).

Ports:
- Clk  in  1  rising-edge clock
- Clr  in  1  synchronous active-high reset
- FR_Ld  in  1  flag register load enable
- MF  in  1  flag source select: 0 = ALU flags, 1 = wr_icc
- alu_flags  in  4  live ALU flags {C,N,V,Z}, bit3 = C, bit0 = Z
- wr_icc  in  4  flag write value {C,N,V,Z} (from ALUOut[23:20])
- ir_hi  in  7  IR[31:25]: [6:5] = op, [4] = annul (ignored), [3:0] = cond
- wim  in  NWINDOWS  window invalid mask
- psr  in  12  PSR[11:0]: bit7 = S, bit5 = ET, [1:0] = CWP
- fr_out  out  4  registered flags {C,N,V,Z}
- BCOND  out  1  branch condition true
- TCOND  out  1  trap condition true
- win_ovf  out  1  WIM bit at (CWP−1) mod NWINDOWS is set
- win_unf  out  1  WIM bit at (CWP+1) mod NWINDOWS is set

Behaviour:
- Flag register update, on rising Clk edge:
  - Clr = 1 → fr_out = 4'b0000. Clr has priority over FR_Ld.
  - Else FR_Ld = 1 → fr_out ← (MF ? wr_icc : alu_flags).
  - Else fr_out holds.
- Reset value of fr_out is 0.
- All other outputs are combinational, with zero latency from inputs and fr_out.
- The condition function uses flags F = fr_out, unless modified by the optional feature. cond → true when:
  - 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V
  - 0100 C|Z; 0101 C; 0110 N; 0111 V
  - 1000 always; 1001 ~Z; 1010 ~(Z|(N^V)); 1011 ~(N^V)
  - 1100 ~(C|Z); 1101 ~C; 1110 ~N; 1111 ~V
- BCOND = cond_true AND op == 2'b00.
- TCOND = cond_true AND op == 2'b10 AND psr[5] (ET). When ET = 0, TCOND = 0.
- For op 01 or 11, both BCOND and TCOND are 0.
- Window checks:
  - win_ovf = wim[(CWP−1) mod NWINDOWS]; win_unf = wim[(CWP+1) mod NWINDOWS].
  - Wrap-around: CWP = 0 → ovf checks wim[NWINDOWS−1]; CWP = NWINDOWS−1 → unf checks wim[0].
- Outputs are never X once Clr has been applied. During a Clr cycle the outputs reflect the pre-reset flags until the edge.

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined: when FR_Ld = 1 in the current cycle, the condition function uses the mux output (MF ? wr_icc : alu_flags) instead of fr_out. This gives same-cycle branch resolution. Clr does not affect the bypass path.
- Undefined: conditions always use fr_out, so a branch sees flags written one cycle later.

Decomposition:
- Shared package `sparc_cc_pkg`:
  - flag bit index constants FLAG_C = 3, FLAG_N = 2, FLAG_V = 1, FLAG_Z = 0;
  - cond-code enum (NEVER, E, LE, L, LEU, CS, NEG, VS, ALWAYS, NE, G, GE, GU, CC, POS, VC);
  - op constants OP_FMT2 = 2'b00, OP_ARITH = 2'b10.
- One natural sub-module: `cc_eval`, a purely combinational mapping of cond[3:0] plus flags[3:0] to a true bit. The 4-bit source mux and register stay inline.

Test Plan:
- Clr = 1 with FR_Ld = 1, alu_flags = 4'hF → after the edge fr_out = 0. Then ir_hi = 7'b0001000 (op 00, cond A) → BCOND = 1, and cond 0001 → BCOND = 0.
- FR_Ld = 1, MF = 0, alu_flags = 4'b0001 (Z) → next cycle fr_out = 0001. Cond 0001 → BCOND = 1; cond 1001 → BCOND = 0; FR_Ld = 0 then holds 0001.
- MF = 1, wr_icc = 4'b0100 (N), FR_Ld = 1 → fr_out = 0100. Cond 0011 (L) → 1; cond 1011 (GE) → 0; cond 0010 (LE) → 1.
- Sweep all 16 conds × 16 flag values with op = 00 against the table. The same sweep with op = 10, ET = 1 → TCOND matches the table. With ET = 0 → TCOND = 0. op = 01 → both 0.
- wim = 4'b0001, CWP = 1 → win_ovf = 1, win_unf = 0. CWP = 3 → win_unf = 1 (wrap). CWP = 0 → ovf checks wim[3] = 0.
- With FLAG_BYPASS_EN: fr_out = 0, FR_Ld = 1, alu_flags = 0001, cond 0001 → BCOND = 1 in the same cycle. Without the macro → 0 until the next cycle.
